// File: rtl/opcode_sequencer_if.sv
// Load/control/opcode bundle between a program source and the opcode sequencer.
// The master drives program loading and run control; the slave presents the opcode stream.
interface opcode_sequencer_if;
   logic       LOAD_EN;
   logic [3:0] LOAD_ADDR;
   logic [3:0] LOAD_DATA;
   logic       START;
   logic       HOLD;
   logic [3:0] OPCODE;
   logic       VALID;
   logic [3:0] PC;
   logic       BUSY;
   logic       DONE;

   modport master (
      output LOAD_EN, LOAD_ADDR, LOAD_DATA, START, HOLD,
      input  OPCODE, VALID, PC, BUSY, DONE
   );

   modport slave (
      input  LOAD_EN, LOAD_ADDR, LOAD_DATA, START, HOLD,
      output OPCODE, VALID, PC, BUSY, DONE
   );
endinterface

// File: rtl/opcode_sequencer.sv
// Small program store plus IDLE/RUN/DONE sequencer that streams one registered opcode per
// unstalled cycle until HALT_OP or the last slot, then parks on NOP_OP.
module opcode_sequencer #(
   parameter int unsigned DEPTH   = 16,
   parameter logic [3:0]  HALT_OP = 4'b1111,
   parameter logic [3:0]  NOP_OP  = 4'b0000
) (
   input logic                CLK,
   input logic                RST,
   opcode_sequencer_if.slave  bus
);

   localparam logic [3:0] LastPc = 4'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e     state_q, state_d;
   logic [3:0] pc_q, pc_d;
   logic [3:0] opcode_q, opcode_d;
   logic       valid_q, valid_d;
   logic [3:0] mem [DEPTH];
   logic [3:0] first_op;
   logic       mem_we;

   // Program store is deliberately outside the reset domain so RST keeps the program.
   assign mem_we = bus.LOAD_EN && !RST && (state_q != StRun);

   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[bus.LOAD_ADDR] <= bus.LOAD_DATA;
      end
   end

   // Write-first bypass when a slot-0 load coincides with START.
   assign first_op = (bus.LOAD_EN && (bus.LOAD_ADDR == 4'd0)) ? bus.LOAD_DATA : mem[0];

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      opcode_d = opcode_q;
      valid_d  = valid_q;
      unique case (state_q)
         StIdle, StDone: begin
            pc_d     = 4'd0;
            opcode_d = NOP_OP;
            valid_d  = 1'b0;
            if (bus.START) begin
               state_d  = StRun;
               opcode_d = first_op;
               valid_d  = 1'b1;
            end
         end
         StRun: begin
            if (!bus.HOLD) begin
               if ((opcode_q == HALT_OP) || (pc_q == LastPc)) begin
                  state_d  = StDone;
                  pc_d     = 4'd0;
                  opcode_d = NOP_OP;
                  valid_d  = 1'b0;
               end else begin
                  pc_d     = pc_q + 4'd1;
                  opcode_d = mem[pc_q + 4'd1];
                  valid_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d  = StIdle;
            pc_d     = 4'd0;
            opcode_d = NOP_OP;
            valid_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= StIdle;
         pc_q     <= 4'd0;
         opcode_q <= NOP_OP;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         opcode_q <= opcode_d;
         valid_q  <= valid_d;
      end
   end

   assign bus.OPCODE = opcode_q;
   assign bus.VALID  = valid_q;
   assign bus.PC     = pc_q;
   assign bus.BUSY   = (state_q == StRun);
   assign bus.DONE   = (state_q == StDone);

endmodule

// File: tb/tb_opcode_sequencer.sv
// Directed bench for opcode_sequencer: a vector table for load/run/hold/restart behaviour and
// hand-written sequences for full-depth runs, mid-run reset and load-during-run.
module tb_opcode_sequencer;

   logic CLK;
   logic RST;

   opcode_sequencer_if bus ();

   opcode_sequencer #(
      .DEPTH   (16),
      .HALT_OP (4'b1111),
      .NOP_OP  (4'b0000)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       rst;
      logic       load_en;
      logic [3:0] load_addr;
      logic [3:0] load_data;
      logic       start;
      logic       hold;
      logic [3:0] e_op;
      logic       e_valid;
      logic [3:0] e_pc;
      logic       e_busy;
      logic       e_done;
   } vec_t;

   vec_t vq[$];
   int   errors = 0;
   int   checks = 0;

   task automatic row(input logic r, input logic le, input logic [3:0] la, input logic [3:0] ld,
                      input logic st, input logic hd, input logic [3:0] op, input logic v,
                      input logic [3:0] pc, input logic b, input logic d);
      vec_t t;
      t = '{rst: r, load_en: le, load_addr: la, load_data: ld, start: st, hold: hd,
            e_op: op, e_valid: v, e_pc: pc, e_busy: b, e_done: d};
      vq.push_back(t);
   endtask

   task automatic drive(input logic r, input logic le, input logic [3:0] la, input logic [3:0] ld,
                        input logic st, input logic hd);
      RST           = r;
      bus.LOAD_EN   = le;
      bus.LOAD_ADDR = la;
      bus.LOAD_DATA = ld;
      bus.START     = st;
      bus.HOLD      = hd;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [3:0] op, input logic v,
                             input logic [3:0] pc, input logic b, input logic d);
      logic [10:0] got, exp;
      got = {bus.OPCODE, bus.VALID, bus.PC, bus.BUSY, bus.DONE};
      exp = {op, v, pc, b, d};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got op=%b valid=%b pc=%0d busy=%b done=%b, want op=%b valid=%b pc=%0d busy=%b done=%b",
                  name, bus.OPCODE, bus.VALID, bus.PC, bus.BUSY, bus.DONE, op, v, pc, b, d);
      end
   endtask

   initial begin
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

      //   rst le  addr  data  st  hd   op    v  pc    busy done
      row(1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 4'd0, 0, 0);  // reset cycle 1
      row(1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 4'd0, 0, 0);  // reset cycle 2
      row(0, 1, 4'h0, 4'h1, 0, 0, 4'h0, 0, 4'd0, 0, 0);  // load slot 0
      row(0, 1, 4'h1, 4'h2, 0, 0, 4'h0, 0, 4'd0, 0, 0);  // load slot 1
      row(0, 1, 4'h2, 4'hF, 0, 0, 4'h0, 0, 4'd0, 0, 0);  // load slot 2 = HALT
      row(0, 0, 4'h0, 4'h0, 1, 0, 4'h1, 1, 4'd0, 1, 0);  // START -> slot 0
      row(0, 0, 4'h0, 4'h0, 0, 0, 4'h2, 1, 4'd1, 1, 0);
      row(0, 0, 4'h0, 4'h0, 0, 0, 4'hF, 1, 4'd2, 1, 0);  // HALT presented with VALID
      row(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 4'd0, 0, 1);  // DONE
      row(0, 0, 4'h0, 4'h0, 1, 0, 4'h1, 1, 4'd0, 1, 0);  // restart from DONE
      row(0, 0, 4'h0, 4'h0, 0, 0, 4'h2, 1, 4'd1, 1, 0);
      row(0, 0, 4'h0, 4'h0, 0, 1, 4'h2, 1, 4'd1, 1, 0);  // hold 1
      row(0, 0, 4'h0, 4'h0, 1, 1, 4'h2, 1, 4'd1, 1, 0);  // hold 2, START ignored
      row(0, 0, 4'h0, 4'h0, 0, 0, 4'hF, 1, 4'd2, 1, 0);
      row(0, 0, 4'h0, 4'h0, 0, 1, 4'hF, 1, 4'd2, 1, 0);  // hold on HALT
      row(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 4'd0, 0, 1);
      row(1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 4'd0, 0, 0);  // back to IDLE
      row(0, 1, 4'h0, 4'h5, 1, 0, 4'h5, 1, 4'd0, 1, 0);  // load+START bypass
      row(0, 0, 4'h0, 4'h0, 0, 0, 4'h2, 1, 4'd1, 1, 0);
      row(0, 0, 4'h0, 4'h0, 0, 0, 4'hF, 1, 4'd2, 1, 0);
      row(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 4'd0, 0, 1);

      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].load_en, vq[i].load_addr, vq[i].load_data, vq[i].start,
               vq[i].hold);
         tick();
         expect_out($sformatf("vec%0d", i), vq[i].e_op, vq[i].e_valid, vq[i].e_pc,
                    vq[i].e_busy, vq[i].e_done);
      end

      // HALT in slot 0 is still shown for one VALID cycle.
      drive(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
      tick();
      expect_out("halt0_load", 4'h0, 1'b0, 4'd0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
      tick();
      expect_out("halt0_run", 4'hF, 1'b1, 4'd0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      tick();
      expect_out("halt0_done", 4'h0, 1'b0, 4'd0, 1'b0, 1'b1);

      // Full-depth program, no HALT; slot 3 writes during RUN must be dropped.
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, 4'(i), 4'h3, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 16; i++) begin
         expect_out($sformatf("full_pc%0d", i), 4'h3, 1'b1, 4'(i), 1'b1, 1'b0);
         drive(1'b0, 1'b1, 4'h3, 4'h9, 1'b0, 1'b0);
         tick();
      end
      expect_out("full_done", 4'h0, 1'b0, 4'd0, 1'b0, 1'b1);

      // Mid-run reset at PC=5, then replay with the program intact.
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         expect_out($sformatf("rr_pc%0d", i), 4'h3, 1'b1, 4'(i), 1'b1, 1'b0);
         tick();
      end
      expect_out("rr_pc5", 4'h3, 1'b1, 4'd5, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 4'h3, 4'h9, 1'b1, 1'b1);
      tick();
      expect_out("rr_reset", 4'h0, 1'b0, 4'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         expect_out($sformatf("replay_pc%0d", i), 4'h3, 1'b1, 4'(i), 1'b1, 1'b0);
         tick();
      end
      expect_out("replay_done", 4'h0, 1'b0, 4'd0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/opcode_sequencer.md
OPCODE_SEQUENCER -- requirements
Module: opcode_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high, ports named CLK and RST.
REQ-002 Parameter DEPTH, 16, number of program slots (PC width 4 bits).
REQ-003 Parameter HALT_OP, 4'b1111, opcode that ends a program.
REQ-004 Parameter NOP_OP, 4'b0000, opcode driven when not running.
REQ-005 CLK  input  1  clock; all state updates on rising edge.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 LOAD_EN  input  1  write LOAD_DATA into program slot LOAD_ADDR.
REQ-008 LOAD_ADDR  input  4  program slot index.
REQ-009 LOAD_DATA  input  4  opcode to store.
REQ-010 START  input  1  begin execution at slot 0.
REQ-011 HOLD  input  1  consumer stall; freezes sequencing.
REQ-012 OPCODE  output  4  registered opcode feeding the CHIP OPCODE input.
REQ-013 VALID  output  1  OPCODE is a program opcode this cycle.
REQ-014 PC  output  4  slot index of the opcode currently on OPCODE.
REQ-015 BUSY  output  1  high in RUN.
REQ-016 DONE  output  1  high in DONE.

Function
REQ-017 The program store SHALL be DEPTH x 4 bits, written on a CLK edge when LOAD_EN=1 and state is IDLE or DONE; LOAD_EN in RUN SHALL be ignored.
REQ-018 The state machine SHALL have states IDLE, RUN, DONE; BUSY=1 only in RUN, DONE=1 only in DONE.
REQ-019 IDLE/DONE: OPCODE=NOP_OP, VALID=0, PC holds 0; START=1 SHALL move to RUN on the same edge, loading PC=0, OPCODE=MEM[0], VALID=1 (one-cycle latency from START).
REQ-020 If LOAD_EN and START coincide with LOAD_ADDR=0, the fetched OPCODE SHALL be LOAD_DATA (write-first bypass).
REQ-021 RUN, HOLD=1: PC, OPCODE, VALID SHALL hold unchanged; START ignored.
REQ-022 RUN, HOLD=0, OPCODE=HALT_OP: next state DONE, OPCODE=NOP_OP, VALID=0, PC=0; the HALT_OP itself SHALL be presented with VALID=1 for at least one cycle.
REQ-023 RUN, HOLD=0, PC=DEPTH-1, OPCODE!=HALT_OP: next state DONE as in REQ-022; PC SHALL NOT wrap.
REQ-024 RUN, HOLD=0 otherwise: PC<=PC+1, OPCODE<=MEM[PC+1], VALID=1; one opcode per unstalled cycle.
REQ-025 START in RUN SHALL be ignored; START in DONE SHALL restart at slot 0 per REQ-019.

Reset
REQ-026 RST=1 SHALL, on the next edge, force IDLE, OPCODE=NOP_OP, VALID=0, PC=0, BUSY=0, DONE=0, with priority over START, HOLD and LOAD_EN.
REQ-027 RST SHALL NOT clear the program store; reset mid-run SHALL abandon the program without side effects.

Verification
REQ-028 RST high 2 cycles -> OPCODE=0000, VALID=0, PC=0, BUSY=0, DONE=0.
REQ-029 Load slots 0..2 = 0001,0010,1111, pulse START -> OPCODE 0001,0010,1111 with VALID=1 on the three cycles after START, PC 0,1,2; then DONE=1, VALID=0, OPCODE=0000.
REQ-030 Same program, HOLD=1 for 2 cycles while OPCODE=0010 -> OPCODE=0010, PC=1, VALID=1 for 3 cycles total, then 1111.
REQ-031 16 slots of 0011, no HALT_OP, START -> 16 VALID cycles, PC 0..15, then DONE; PC never returns to 0 while VALID.
REQ-032 RST during RUN at PC=5 -> IDLE outputs next cycle; START again replays from PC=0 with unchanged contents.
REQ-033 LOAD_EN to slot 3 during RUN -> slot 3 unchanged; LOAD_EN+START with LOAD_ADDR=0, LOAD_DATA=0101 in IDLE -> first OPCODE=0101.
